// File: rtl/lifo_pkg.sv
// lifo_pkg: shared state encoding and depth helper for the LIFO read-side engine.
package lifo_pkg;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_DRAIN, S_FINISH} pop_state_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry valid/ready output register carrying data and a last marker.
module stream_out_reg #(
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [data_width-1:0] data_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [data_width-1:0] data_o,
    output logic                  last_o
);

    logic                  valid_q;
    logic                  last_q;
    logic [data_width-1:0] data_q;

    // Data is only written on load, so it stays put while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= last_i;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer: pops a requested number of stack entries onto a valid/ready
// stream, newest first, flagging underflow and reporting completion.
module lifo_pop_streamer
    import lifo_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width:0]   count,
    input  logic                  empty,
    input  logic [data_width-1:0] r_data,
    output logic                  pop,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  underflow,
    output logic [addr_width:0]   popped
);

    localparam int unsigned CW = addr_width + 1;
    localparam logic [CW-1:0] DEPTH = CW'(depth_of(addr_width));
    localparam logic [CW-1:0] ONE = CW'(1);

    pop_state_t    state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] popped_q, popped_d;
    logic          underflow_q, underflow_d;
    logic          out_free;

    assign out_free = !m_valid || m_ready;
    assign pop      = (state_q == S_POP) && !empty && (remaining_q != '0) && out_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            popped_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            popped_q    <= popped_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        popped_d    = popped_q;
        underflow_d = underflow_q;
        case (state_q)
            S_IDLE: if (start) begin
                remaining_d = (count > DEPTH) ? DEPTH : count;
                popped_d    = '0;
                underflow_d = 1'b0;
                state_d     = (count == '0) ? S_FINISH : S_POP;
            end
            S_POP: if (pop) begin
                remaining_d = remaining_q - ONE;
                popped_d    = popped_q + ONE;
                state_d     = (remaining_q == ONE) ? S_DRAIN : S_POP;
            end else if (remaining_q == '0) begin
                state_d = S_DRAIN;
            end else if (empty) begin
                // Skip DRAIN when the output register empties on this same edge.
                underflow_d = 1'b1;
                state_d     = out_free ? S_FINISH : S_DRAIN;
            end
            S_DRAIN: state_d = out_free ? S_FINISH : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    stream_out_reg #(.data_width(data_width)) u_out (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (pop),
        .data_i (r_data),
        .last_i (remaining_q == ONE),
        .ready_i(m_ready),
        .valid_o(m_valid),
        .data_o (m_data),
        .last_o (m_last)
    );

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_FINISH;
    assign underflow = underflow_q;
    assign popped    = popped_q;

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// tb_lifo_pop_streamer: scoreboard bench with a behavioural stack feeding the streamer.
module tb_lifo_pop_streamer;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 0;
    logic          reset = 0;
    logic          start = 0;
    logic [AW:0]   count = '0;
    logic          m_ready = 1;
    logic          empty;
    logic [DW-1:0] r_data;
    logic          pop, m_valid, m_last, busy, done, underflow;
    logic [DW-1:0] m_data;
    logic [AW:0]   popped;

    always #5 clk = ~clk;

    lifo_pop_streamer #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .empty(empty),
        .r_data(r_data), .pop(pop), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
        .underflow(underflow), .popped(popped)
    );

    logic [DW-1:0] stk [16];
    int            sp = 0;
    logic          push_en = 0;
    logic [DW-1:0] push_val = '0;

    assign empty  = (sp == 0);
    assign r_data = (sp == 0) ? '0 : stk[sp-1];

    always @(posedge clk) begin
        if (push_en) begin
            stk[sp] <= push_val;
            sp <= sp + 1;
        end else if (reset && pop) begin
            sp <= sp - 1;
        end
    end

    typedef struct { logic [DW-1:0] d; logic l; } word_t;
    typedef struct { logic uf; int n; bit zero; int c; } done_t;
    word_t sb[$];
    done_t dq[$];

    int cyc = 0, last_hs = 0, done_cnt = 0, done_cyc = 0;
    int checks = 0, passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: compares every presented word and every done pulse against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (empty) chk(!pop, "pop_while_empty", int'(pop), 0);
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk(0, "unexpected_word", int'(m_data), 0);
                end else begin
                    chk(m_data == sb[0].d, "word_data", int'(m_data), int'(sb[0].d));
                    chk(m_last == sb[0].l, "word_last", int'(m_last), int'(sb[0].l));
                    if (m_ready) begin
                        void'(sb.pop_front());
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk(0, "unexpected_done", 1, 0);
                end else begin
                    done_t e;
                    e = dq.pop_front();
                    chk(underflow == e.uf, "done_underflow", int'(underflow), int'(e.uf));
                    chk(int'(popped) == e.n, "done_popped", int'(popped), e.n);
                    chk(cyc == (e.zero ? e.c + 1 : last_hs + 1), "done_time", cyc,
                        e.zero ? e.c + 1 : last_hs + 1);
                    chk(sb.size() == 0, "words_missing", sb.size(), 0);
                end
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        push_en = 1;
        push_val = v;
        cycle();
        push_en = 0;
    endtask

    task automatic exp_word(input logic [DW-1:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        sb.push_back(w);
    endtask

    task automatic exp_done(input logic uf, input int n, input bit zero);
        done_t e;
        e.uf = uf;
        e.n = n;
        e.zero = zero;
        e.c = cyc;
        dq.push_back(e);
    endtask

    task automatic go(input int n);
        start = 1;
        count = n[AW:0];
        cycle();
        start = 0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (toggle) m_ready = ~m_ready;
            cycle();
            if (done_cnt != d0) begin
                m_ready = 1;
                return;
            end
        end
        m_ready = 1;
        chk(0, "done_timeout", 0, 1);
    endtask

    initial begin
        int sc, d0;
        #3;
        chk(!m_valid && !m_last && m_data == 0, "reset_stream", int'(m_data), 0);
        chk(!busy && !done && !pop, "reset_ctrl", int'({busy, done, pop}), 0);
        chk(!underflow && popped == 0, "reset_status", int'(popped), 0);
        cycle();
        cycle();
        reset = 1;
        cycle();

        // Basic four-word transfer at full throughput.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        exp_word(8'h44, 0); exp_word(8'h33, 0); exp_word(8'h22, 0); exp_word(8'h11, 1);
        exp_done(0, 4, 0);
        sc = cyc;
        go(4);
        chk(busy, "busy_after_start", int'(busy), 1);
        wait_done(40, 0);
        chk(done_cyc == sc + 6, "basic_latency", done_cyc - sc, 6);

        // Underflow: two entries, five requested.
        push(8'hA1); push(8'hB2);
        exp_word(8'hB2, 0); exp_word(8'hA1, 0);
        exp_done(1, 2, 0);
        go(5);
        wait_done(40, 0);

        // Full stack with toggling back-pressure.
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
        for (int i = 15; i >= 0; i--) exp_word(8'hC0 + 8'(i), i == 0);
        exp_done(0, 16, 0);
        go(16);
        wait_done(200, 1);
        chk(sp == 0, "full_stack_empty", sp, 0);

        // Reset after three of eight pops.
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        for (int i = 7; i >= 0; i--) exp_word(8'h50 + 8'(i), i == 0);
        exp_done(0, 8, 0);
        go(8);
        for (int i = 0; i < 20 && popped != 3; i++) cycle();
        #1 reset = 0;
        #1;
        chk(!m_valid && !busy && !pop, "async_reset_outputs", int'({m_valid, busy, pop}), 0);
        chk(popped == 0, "async_reset_popped", int'(popped), 0);
        sb.delete();
        dq.delete();
        cycle();
        reset = 1;
        cycle();
        chk(!busy && !done, "idle_after_reset", int'({busy, done}), 0);
        chk(sp == 5, "stack_after_reset", sp, 5);
        exp_word(8'h54, 0); exp_word(8'h53, 1);
        exp_done(0, 2, 0);
        go(2);
        wait_done(40, 0);

        // Zero-length request with entries still on the stack.
        d0 = done_cnt;
        exp_done(0, 0, 1);
        go(0);
        repeat (3) begin
            @(negedge clk);
            chk(!pop && !m_valid && !m_last, "zero_quiet", int'({pop, m_valid, m_last}), 0);
        end
        chk(done_cnt == d0 + 1, "zero_done_count", done_cnt - d0, 1);
        cycle();

        // Second start mid-transfer is ignored.
        exp_word(8'h52, 0); exp_word(8'h51, 0); exp_word(8'h50, 1);
        exp_done(0, 3, 0);
        m_ready = 0;
        go(3);
        cycle();
        start = 1;
        count = 5'd1;
        cycle();
        start = 0;
        wait_done(60, 1);
        chk(sp == 0, "mid_start_stack", sp, 0);

        repeat (3) cycle();
        chk(sb.size() == 0 && dq.size() == 0, "queues_drained", sb.size() + dq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
